// File: rtl/dmem_wait_responder_if.sv
// rtl/dmem_wait_responder_if.sv - load/store request/ready bundle between core and data memory
interface dmem_wait_responder_if;
  logic        req;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] rd;
  logic        err;

  modport master (
    output req, we, a, wd, be,
    input  ready, rd, err
  );

  modport slave (
    input  req, we, a, wd, be,
    output ready, rd, err
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// rtl/dmem_wait_responder.sv - word-addressed data memory answering each access after WAIT_CYCLES wait states
// Defining DMEM_STATS_EN adds saturating rd_count/wr_count ports for successful loads and stores.
module dmem_wait_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input logic                  clk,
  input logic                  reset,
  dmem_wait_responder_if.slave bus
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
`endif
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAST_WAIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT             state;
  stateT             nextState;
  logic [3:0]        waitCnt;

  logic              weQ;
  logic [31:0]       aQ;
  logic [31:0]       wdQ;
  logic [3:0]        beQ;

  logic              accWe;
  logic [31:0]       accA;
  logic [31:0]       accWd;
  logic [3:0]        accBe;
  logic [32:0]       offset;
  logic [IDX_W-1:0]  accIdx;
  logic              accErr;
  logic              enterResp;
  logic              doWrite;

  logic              readyQ;
  logic              errQ;
  logic [31:0]       rdQ;

  logic [31:0]       mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.req) nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (waitCnt == LAST_WAIT) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the acceptance edge, so the live
  // inputs must be used there; otherwise the latched copy is authoritative.
  always_comb begin
    accWe = weQ;
    accA  = aQ;
    accWd = wdQ;
    accBe = beQ;
    if (state == IDLE) begin
      accWe = bus.we;
      accA  = bus.a;
      accWd = bus.wd;
      accBe = bus.be;
    end
    // A borrow sets bit 32, so one unsigned compare catches below-base and past-end.
    offset    = {1'b0, accA} - {1'b0, BASE_ADDR};
    accIdx    = IDX_W'(offset >> 2);
    accErr    = (accA[1:0] != 2'b00) || (offset >= SPAN);
    enterResp = (nextState == RESP) && (state != RESP);
    doWrite   = enterResp && accWe && !accErr;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req) begin
      weQ <= bus.we;
      aQ  <= bus.a;
      wdQ <= bus.wd;
      beQ <= bus.be;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      waitCnt <= 4'd0;
      readyQ  <= 1'b0;
      errQ    <= 1'b0;
      rdQ     <= 32'd0;
    end else begin
      waitCnt <= (state == WAIT) ? waitCnt + 4'd1 : 4'd0;
      readyQ  <= enterResp;
      errQ    <= enterResp && accErr;
      rdQ     <= (enterResp && !accWe && !accErr) ? mem[accIdx] : 32'd0;
    end
  end

  // The array has no reset; gating on reset keeps an abandoned store from committing.
  always_ff @(posedge clk) begin
    if (reset && doWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (accBe[i]) mem[accIdx][8*i +: 8] <= accWd[8*i +: 8];
      end
    end
  end

  assign bus.ready = readyQ;
  assign bus.err   = errQ;
  assign bus.rd    = rdQ;

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (state == RESP && !errQ) begin
      if (weQ) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb/tb_dmem_wait_responder.sv - scoreboard bench for two responders (2 and 0 wait states)
module tb_dmem_wait_responder;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
    bit          chkRd;
  } expT;

  logic clk;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;
  bit   started;

  expT         q0[$];
  expT         q1[$];
  logic [31:0] mm [2][64];
  bit          kn [2][64];

  logic [15:0] rdCnt0, wrCnt0, rdCnt1, wrCnt1;

  dmem_wait_responder_if b0 ();
  dmem_wait_responder_if b1 ();

  dmem_wait_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut0 (
    .clk      (clk),
    .reset    (reset),
    .bus      (b0.slave)
`ifdef DMEM_STATS_EN
    ,
    .rd_count (rdCnt0),
    .wr_count (wrCnt0)
`endif
  );

  dmem_wait_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .bus      (b1.slave)
`ifdef DMEM_STATS_EN
    ,
    .rd_count (rdCnt1),
    .wr_count (wrCnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] bytes);
    if (sel == 0) begin
      b0.req = r; b0.we = w; b0.a = addr; b0.wd = data; b0.be = bytes;
    end else begin
      b1.req = r; b1.we = w; b1.a = addr; b1.wd = data; b1.be = bytes;
    end
  endtask

  // Expected response for an access accepted on edge n, with the model memory updated.
  task automatic push(input int sel, input int n, input logic w, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] bytes);
    expT        e;
    logic [5:0] idx;
    idx     = addr[7:2];
    e.err   = (addr[1:0] != 2'b00) || (addr >= 32'h100);
    e.rd    = 32'd0;
    e.chkRd = 1'b1;
    e.cyc   = n + ((sel == 0) ? 2 : 0);
    if (!e.err) begin
      if (w) begin
        for (int i = 0; i < 4; i++) if (bytes[i]) mm[sel][idx][8*i +: 8] = data[8*i +: 8];
        if (bytes == 4'hF) kn[sel][idx] = 1'b1;
      end else begin
        e.rd    = mm[sel][idx];
        e.chkRd = kn[sel][idx];
      end
    end
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic waitDone(input int sel);
    int left;
    int n;
    left = 40;
    n    = (sel == 0) ? q0.size() : q1.size();
    while (left > 0 && n != 0) begin
      @(posedge clk);
      left--;
      n = (sel == 0) ? q0.size() : q1.size();
    end
    if (n != 0) begin
      check("ready_timeout", 32'(n), 32'd0);
      if (sel == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic access(input int sel, input logic w, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] bytes);
    @(negedge clk);
    drive(sel, 1'b1, w, addr, data, bytes);
    @(posedge clk); #1;
    push(sel, cyc, w, addr, data, bytes);
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitDone(sel);
  endtask

  always @(negedge clk) begin : mon0
    expT e;
    if (started) begin
      if (b0.ready) begin
        if (q0.size() == 0) begin
          check("spurious_ready0", 32'(b0.ready), 32'd0);
        end else begin
          e = q0.pop_front();
          check("latency0", 32'(cyc), 32'(e.cyc));
          check("err0", 32'(b0.err), 32'(e.err));
          if (e.chkRd) check("rd0", b0.rd, e.rd);
        end
      end else begin
        check("quiet0", b0.rd | 32'(b0.err), 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon1
    expT e;
    if (started) begin
      if (b1.ready) begin
        if (q1.size() == 0) begin
          check("spurious_ready1", 32'(b1.ready), 32'd0);
        end else begin
          e = q1.pop_front();
          check("latency1", 32'(cyc), 32'(e.cyc));
          check("err1", 32'(b1.err), 32'(e.err));
          if (e.chkRd) check("rd1", b1.rd, e.rd);
        end
      end else begin
        check("quiet1", b1.rd | 32'(b1.err), 32'd0);
      end
    end
  end

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    started     = 1'b0;
    for (int s = 0; s < 2; s++) for (int i = 0; i < 64; i++) begin
      mm[s][i] = 32'h0;
      kn[s][i] = 1'b0;
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", 32'(b0.ready), 32'd0);
    check("rst_err0", 32'(b0.err), 32'd0);
    check("rst_rd0", b0.rd, 32'd0);
    check("rst_ready1", 32'(b1.ready), 32'd0);
    check("rst_err1", 32'(b1.err), 32'd0);
    check("rst_rd1", b1.rd, 32'd0);
    reset   = 1'b1;
    started = 1'b1;

    // full-word store/load, byte-lane merges, be=0, last word
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0);
    access(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0);
    access(0, 1'b1, 32'h10, 32'h00550000, 4'b0100);
    access(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
    access(0, 1'b0, 32'h10, 32'h0, 4'hF);
    access(0, 1'b1, 32'hFC, 32'h600DF00D, 4'hF);
    access(0, 1'b0, 32'hFC, 32'h0, 4'h0);

    // misaligned and out of range; 0x100 would alias word 0 if unchecked
    access(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
    access(0, 1'b0, 32'h12, 32'h0, 4'h0);
    access(0, 1'b1, 32'h100, 32'h13579BDF, 4'hF);
    access(0, 1'b1, 32'h102, 32'h13579BDF, 4'hF);
    access(0, 1'b0, 32'h0, 32'h0, 4'h0);

    // inputs change and req toggles while busy; held req is taken 4 edges later
    access(0, 1'b1, 32'h34, 32'h0, 4'hF);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h30, 32'h11112222, 4'hF);
    @(posedge clk); #1;
    n = cyc;
    push(0, n, 1'b1, 32'h30, 32'h11112222, 4'hF);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h34, 32'h99999999, 4'hF);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h38, 32'h77777777, 4'hF);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h34, 32'h99999999, 4'hF);
    @(posedge clk);
    @(posedge clk); #1;
    push(0, n + 4, 1'b1, 32'h34, 32'h99999999, 4'hF);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    waitDone(0);
    access(0, 1'b0, 32'h30, 32'h0, 4'h0);
    access(0, 1'b0, 32'h34, 32'h0, 4'h0);

    // reset in WAIT, then reset on the very edge that would commit
    access(0, 1'b1, 32'h20, 32'h5555AAAA, 4'hF);
    for (int d = 1; d <= 2; d++) begin
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (d - 1) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("abort_ready", 32'(b0.ready), 32'd0);
      repeat (6) @(posedge clk);
      access(0, 1'b0, 32'h20, 32'h0, 4'h0);
    end

    // zero wait states: response on the acceptance edge
    access(1, 1'b0, 32'h40, 32'h0, 4'h0);
    access(1, 1'b0, 32'h44, 32'h0, 4'h0);
    access(1, 1'b0, 32'h48, 32'h0, 4'h0);
    access(1, 1'b0, 32'h4D, 32'h0, 4'h0);
`ifdef DMEM_STATS_EN
    @(negedge clk);
    check("rd_count", {16'd0, rdCnt1}, 32'd3);
    check("wr_count", {16'd0, wrCnt1}, 32'd0);
`endif
    access(1, 1'b1, 32'h40, 32'h01234567, 4'hF);
    access(1, 1'b1, 32'h40, 32'h0000CD00, 4'b0010);
    access(1, 1'b0, 32'h40, 32'h0, 4'h0);
    access(1, 1'b1, 32'h200, 32'h0, 4'hF);

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
